// File: rtl/dsp_elastic_pipe.sv
// dsp_elastic_pipe: DEPTH-stage elastic register pipeline with a per-stage
// valid bit and valid/ready handshake on both ends. Empty stages accept
// from upstream even while downstream is stalled, so bubbles collapse.
// The ready chain is purely combinational from out_ready back to in_ready.
module dsp_elastic_pipe #(
   parameter int WIDTH = 18,
   parameter int DEPTH = 2,
   parameter int CNT_W = $clog2(DEPTH + 1)
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             CE,
   input  logic             flush,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] in_data,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] out_data,
   output logic [CNT_W-1:0] count
);

   // Stage state: valid bit and data word per stage.
   logic [DEPTH-1:0] valid_reg;
   logic [WIDTH-1:0] data_reg [DEPTH];

   // What each stage would load when it advances: the input for stage 0,
   // the previous stage for every other stage.
   logic [DEPTH-1:0] src_valid;
   logic [WIDTH-1:0] src_data [DEPTH];

   // rdy[i] is high when stage i may load this edge; rdy[DEPTH] is the
   // downstream sink. Flush and a low CE block every stage.
   logic [DEPTH:0]   rdy;
   logic [CNT_W-1:0] count_next;

   assign rdy[DEPTH] = out_ready & CE & ~flush;

   genvar gi;
   generate
      for (gi = 0; gi < DEPTH; gi++) begin : g_stage
         if (gi == 0) begin : g_head
            assign src_valid[gi] = in_valid;
            assign src_data[gi]  = in_data;
         end else begin : g_body
            assign src_valid[gi] = valid_reg[gi-1];
            assign src_data[gi]  = data_reg[gi-1];
         end
         // A stage can take a new word when it is empty or its own word moves on.
         assign rdy[gi] = (~valid_reg[gi] | rdy[gi+1]) & CE & ~flush;
      end
   endgenerate

   // Advance stages; data only follows a valid source so an empty stage
   // keeps its last word (out_data holds while the pipe drains empty).
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         valid_reg <= '0;
         for (int i = 0; i < DEPTH; i++) begin
            data_reg[i] <= '0;
         end
      end else if (flush) begin
         valid_reg <= '0;
         for (int i = 0; i < DEPTH; i++) begin
            data_reg[i] <= '0;
         end
      end else begin
         for (int i = 0; i < DEPTH; i++) begin
            if (rdy[i]) begin
               valid_reg[i] <= src_valid[i];
               if (src_valid[i]) begin
                  data_reg[i] <= src_data[i];
               end
            end
         end
      end
   end

   // Occupancy is the population count of the stage valid bits.
   always_comb begin
      count_next = '0;
      for (int i = 0; i < DEPTH; i++) begin
         count_next = count_next + CNT_W'(valid_reg[i]);
      end
   end

   // Nothing is accepted while reset is held, even though the stages read empty.
   assign in_ready  = rdy[0] & ~rst;
   assign out_valid = valid_reg[DEPTH-1];
   assign out_data  = data_reg[DEPTH-1];
   assign count     = count_next;

endmodule
